gups_mem_responder: RTL

Memory-side responder for the GUPS update-port protocol. Serves the initiator's read-modify-write sequence from an on-chip 64-bit word array:
- a read phase (`req`=1, `wr`=0) is answered with a `ready` pulse carrying the stored word;
- a write phase (`req`=1, `wr`=1) stores the returned word and is acknowledged with a second `ready` pulse.

It sits directly opposite the GUPS generator on its `address`/`dout`/`req`/`wr`/`ready` bus and provides the target table for update benchmarks and bring-up.

---
 rtl/gups_mem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gups_mem_responder.sv
// GUPS update-port memory responder: serves read-modify-write transactions
// from an on-chip table of 64-bit words, clearing the table after reset.
module gups_mem_responder #(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [63:0] address,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        ready,
  output logic        busy,
  output logic        oob,
  output logic [31:0] update_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   inr_q, inr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [63:0]            dout_q, dout_d;
  logic                   ready_q, ready_d;
  logic                   oob_q, oob_d;
  logic [31:0]            upd_q, upd_d;

  logic [63:0]            mem [DEPTH];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [63:0]            mem_wdata;

  logic [ADDR_BITS-1:0]   addr_idx;
  logic                   addr_inr;
  logic [ADDR_BITS-1:0]   rd_idx;
  logic [63:0]            rd_word;

  assign addr_idx = address[ADDR_BITS-1:0];
  assign addr_inr = (address[63:ADDR_BITS] == '0);
  assign rd_idx   = (state_q == S_IDLE) ? addr_idx : idx_q;
  assign rd_word  = mem[rd_idx];

  // Next-state, response and table-write decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    inr_d     = inr_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    ready_d   = 1'b0;
    oob_d     = oob_q;
    upd_d     = upd_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req && !wr) begin
          idx_d = addr_idx;
          inr_d = addr_inr;
          if (!addr_inr) oob_d = 1'b1;
          // A latency of one answers straight from the accepting edge.
          if (READ_LATENCY == 1) begin
            dout_d  = addr_inr ? rd_word : '0;
            ready_d = 1'b1;
            state_d = S_WR_WAIT;
          end else begin
            cnt_d   = 4'(READ_LATENCY - 1);
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 4'd1) begin
          dout_d  = inr_q ? rd_word : '0;
          ready_d = 1'b1;
          state_d = S_WR_WAIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (wr && !ready_q) begin
          // A write during the read-ready cycle waits one cycle so the
          // two acknowledges can never merge into a double-width pulse.
          if (inr_q) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = din;
            upd_d     = upd_q + 32'd1;
          end
          ready_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      idx_q   <= '0;
      inr_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      oob_q   <= 1'b0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      inr_q   <= inr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      oob_q   <= oob_d;
      upd_q   <= upd_d;
    end
  end

  // Table write port; reset suppresses any pending write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dout         = dout_q;
  assign ready        = ready_q;
  assign busy         = (state_q == S_CLEAR);
  assign oob          = oob_q;
  assign update_count = upd_q;

endmodule
